lsu_req_queue: RTL
==================

Name: lsu_req_queue

Overview:
- Parametrised load/store request queue between the execute stage and the data-cache request port.
- Generalises the execute stage's fixed 32-bit, single-request memory path in four ways:
  - configurable data width (32/64);
  - a DEPTH-entry buffer of outstanding un-issued requests;
  - tagged requests;
  - doubleword access.
- Computes alignment exception, byte strobes and lane-replicated write data on entry.
- Issues entries in order to the dcache with a valid/addr_ok handshake.

Parameters:
- DATA_W, 32, cache data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- DEPTH, 4, queue entries; power of two, >= 2.
- TAG_W, 4, opaque request tag returned with each issued request.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  queue can accept a request.
- req_op  in  1  1 = store, 0 = load.
- req_size  in  3  0 = byte, 1 = half, 2 = word, 3 = dword; others illegal.
- req_addr  in  ADDR_W  virtual/physical address.
- req_wdata  in  DATA_W  store data, right-justified.
- req_tag  in  TAG_W  request tag.
- req_ale  out  1  request is misaligned or illegal (combinational on req_*).
- flush  in  1  pipeline flush (exception/ertn/refetch).
- data_valid  out  1  request to dcache.
- data_op  out  1  1 = store.
- data_size  out  3  size code, passed through.
- data_addr  out  ADDR_W  address.
- data_wstrb  out  DATA_W/8  byte strobes (all ones for loads).
- data_wdata  out  DATA_W  lane-replicated store data.
- data_tag  out  TAG_W  tag of the issued entry.
- data_addr_ok  in  1  dcache accepts the current request.
- q_count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - read pointer, write pointer and count cleared;
  - all entry valid bits cleared;
  - data_valid=0, q_count=0.
  - req_ready=0 while resetn=0, and equals 1 from the first cycle after reset releases.
- Alignment:
  - req_ale=1 when: size 1 and addr[0]; size 2 and addr[1:0]!=0; size 3 and (DATA_W==32 or addr[2:0]!=0); or size>3.
- Accept:
  - A handshake is req_valid && req_ready.
  - req_ready = (count<DEPTH) && !flush.
  - An accepted request with req_ale=1 completes the handshake but is NOT enqueued; the execute stage raises ALE from req_ale.
- Enqueue:
  - Stores: strobes = size mask shifted by the lane offset addr[$clog2(DATA_W/8)-1:0].
  - Write data is replicated across lanes: byte ×DATA_W/8, half ×DATA_W/16, word ×DATA_W/32; dword is passed through.
  - Loads: wstrb = all ones, wdata = 0.
  - Entry fields are registered.
- Latency: an enqueued entry may appear on data_* no earlier than the next cycle (registered head).
- Issue:
  - data_valid = head entry valid && !flush.
  - data_* are driven from the head entry and are stable while data_valid && !data_addr_ok.
  - data_valid && data_addr_ok pops the head; the next entry is presented in the following cycle.
- Full: with count==DEPTH, req_ready=0 even if a pop occurs in the same cycle (no full bypass).
- Simultaneous push and pop: count unchanged and pointers both advance.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush:
  - At the clk edge with flush=1, all entries are invalidated, pointers and count reset, and any same-cycle enqueue is dropped.
  - data_valid=0 during the flush cycle, so no handshake completes.
  - Flush has priority over reset-free pops and pushes.
- Order: strictly in-order issue; there is no load/store reordering.

Optional Feature:
- Macro: LSU_REQ_BYPASS_EN.
- Defined:
  - When the queue is empty and a non-ALE request is accepted, it drives data_* combinationally in the same cycle.
  - If data_addr_ok=1 that cycle, the request is not enqueued (zero-latency issue).
  - Otherwise it is enqueued normally.
- Undefined:
  - Minimum issue latency is 1 cycle.

Decomposition:
- Package lsu_pkg holds:
  - size code constants (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - the entry struct typedef (op, size, addr, wstrb, wdata, tag);
  - an ale_check function.
- Sub-module lsu_align (combinational; computes strobe, replicated wdata and ale) is instantiated once on the enqueue path.

Test Plan:
1. DATA_W=32, store half, addr=0x1002, wdata=0x0000BEEF, addr_ok held 1 -> next cycle data_valid=1, wstrb=4'b1100, wdata=0xBEEFBEEF, pops in one cycle, q_count returns to 0.
2. Store word, addr=0x1001 -> req_ale=1 in the same cycle; nothing enqueued; q_count=0; data_valid stays 0.
3. DEPTH=4, addr_ok=0, push 5 requests -> req_ready=0 after the 4th; q_count=4; with addr_ok=1, issue order and tags are 0,1,2,3; count reaches 0 after 4 cycles.
4. Queue holding 3 entries, flush=1 for one cycle together with a push -> data_valid=0 that cycle; q_count=0 next cycle; the pushed entry is never issued.
5. DATA_W=64, load dword, addr=0x2008 -> data_size=3, wstrb=8'hFF; with DATA_W=32 the same request -> req_ale=1.
6. Continuous push and pop for 2×DEPTH+1 cycles -> pointer wrap is correct, q_count is constant, and no entry is lost or duplicated; with LSU_REQ_BYPASS_EN on an empty queue, data_valid=1 in the accept cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, entry layout and alignment check for the LSU request queue
package lsu_pkg;

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;

    localparam int LSU_MAX_ADDR_W = 64;
    localparam int LSU_MAX_DATA_W = 64;
    localparam int LSU_MAX_TAG_W  = 16;

    // Widest entry layout; narrower builds zero-extend on write and slice on read.
    typedef struct packed {
        logic                          op;
        logic [2:0]                    size;
        logic [LSU_MAX_ADDR_W-1:0]     addr;
        logic [LSU_MAX_DATA_W/8-1:0]   wstrb;
        logic [LSU_MAX_DATA_W-1:0]     wdata;
        logic [LSU_MAX_TAG_W-1:0]      tag;
    } lsu_entry_t;

    function automatic logic ale_check(input logic [2:0] size, input logic [2:0] addr_lo,
                                       input logic dword_ok);
        logic ale;
        case (size)
            SZ_BYTE:  ale = 1'b0;
            SZ_HALF:  ale = addr_lo[0];
            SZ_WORD:  ale = |addr_lo[1:0];
            SZ_DWORD: ale = !dword_ok || (|addr_lo);
            default:  ale = 1'b1;
        endcase
        return ale;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational strobe, lane replication and alignment check for one request
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  op_i,
    input  logic [2:0]            size_i,
    input  logic [2:0]            addr_lo_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  ale_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    logic [STRB_W-1:0] size_mask;

    always_comb begin
        size_mask = '1;
        wstrb_o   = '1;
        wdata_o   = '0;
        ale_o     = ale_check(size_i, addr_lo_i, DATA_W == 64);
        case (size_i)
            SZ_BYTE: size_mask = STRB_W'(8'h01);
            SZ_HALF: size_mask = STRB_W'(8'h03);
            SZ_WORD: size_mask = STRB_W'(8'h0f);
            default: size_mask = '1;
        endcase
        // Loads keep all-ones strobes and zero data.
        if (op_i) begin
            wstrb_o = size_mask << addr_lo_i[OFF_W-1:0];
            case (size_i)
                SZ_BYTE: wdata_o = {STRB_W{wdata_i[7:0]}};
                SZ_HALF: wdata_o = {(DATA_W/16){wdata_i[15:0]}};
                SZ_WORD: wdata_o = {(DATA_W/32){wdata_i[31:0]}};
                default: wdata_o = wdata_i;
            endcase
        end
    end

endmodule

// File: rtl/lsu_req_queue.sv
// rtl/lsu_req_queue.sv - in-order LSU request queue to the dcache; LSU_REQ_BYPASS_EN adds empty-queue bypass
module lsu_req_queue
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [2:0]                 req_size,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       req_ale,
    input  logic                       flush,
    output logic                       data_valid,
    output logic                       data_op,
    output logic [2:0]                 data_size,
    output logic [ADDR_W-1:0]          data_addr,
    output logic [DATA_W/8-1:0]        data_wstrb,
    output logic [DATA_W-1:0]          data_wdata,
    output logic [TAG_W-1:0]           data_tag,
    input  logic                       data_addr_ok,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    lsu_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [STRB_W-1:0] enq_wstrb;
    logic [DATA_W-1:0] enq_wdata;
    logic              enq_ale;
    lsu_entry_t        enq_entry, out_entry;
    logic              accept, push, pop, head_vld, bypass;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .op_i      (req_op),
        .size_i    (req_size),
        .addr_lo_i (req_addr[2:0]),
        .wdata_i   (req_wdata),
        .wstrb_o   (enq_wstrb),
        .wdata_o   (enq_wdata),
        .ale_o     (enq_ale)
    );

    always_comb begin
        enq_entry       = '0;
        enq_entry.op    = req_op;
        enq_entry.size  = req_size;
        enq_entry.addr  = LSU_MAX_ADDR_W'(req_addr);
        enq_entry.wstrb = (LSU_MAX_DATA_W/8)'(enq_wstrb);
        enq_entry.wdata = LSU_MAX_DATA_W'(enq_wdata);
        enq_entry.tag   = LSU_MAX_TAG_W'(req_tag);
    end

    assign req_ale   = enq_ale;
    assign req_ready = resetn && (count_q < FULL_CNT) && !flush;
    assign accept    = req_valid && req_ready;
    assign head_vld  = vld_q[rd_ptr_q];

`ifdef LSU_REQ_BYPASS_EN
    assign bypass = accept && !enq_ale && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign out_entry  = bypass ? enq_entry : entries_q[rd_ptr_q];
    assign data_valid = (head_vld || bypass) && !flush;
    assign data_op    = out_entry.op;
    assign data_size  = out_entry.size;
    assign data_addr  = out_entry.addr[ADDR_W-1:0];
    assign data_wstrb = out_entry.wstrb[STRB_W-1:0];
    assign data_wdata = out_entry.wdata[DATA_W-1:0];
    assign data_tag   = out_entry.tag[TAG_W-1:0];
    assign q_count    = count_q;

    // A bypassed request taken by the dcache in its accept cycle never occupies a slot.
    assign pop  = head_vld && data_valid && data_addr_ok;
    assign push = accept && !enq_ale && !(bypass && data_addr_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) vld_q[wr_ptr_q] <= 1'b1;
            if (pop)  vld_q[rd_ptr_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries_q[wr_ptr_q] <= enq_entry;
    end

endmodule
